// File: rtl/ir_key_scheduler.sv
// ir_key_scheduler
//
// Turns decoded IR remote frames into a clean key-event stream. New frames are detected on the
// rising edge of press. A frame carrying the same code as the key being held, and arriving
// inside the hold window, counts as a repeat frame. It does not count as a fresh press. Events
// are queued in a 4-entry FIFO behind a valid/ready handshake.
//
// Build option:
//   IR_AUTOREPEAT_EN  When defined, held-key repeat frames raise auto-repeat events and the FIFO
//                     stores the repeat flag (9-bit entries). When undefined, repeat frames only
//                     refresh the hold state, key_repeat is tied to 0 and entries are 8 bits.
//
// Ports:
//   clk         in   1 MHz system clock
//   rst         in   synchronous, active-high reset
//   code[7:0]   in   decoded command byte, valid while press=1
//   press       in   frame-complete level; a rising edge marks a new frame
//   key_ready   in   consumer accepts the head entry
//   key_code    out  head-entry command byte (0 when empty)
//   key_repeat  out  head entry is an auto-repeat event
//   key_valid   out  FIFO not empty
//   fifo_level  out  number of queued entries, 0..4
//   overflow    out  sticky, an event was dropped on a full FIFO

module ir_key_scheduler #(
    parameter logic [19:0] HOLD_WINDOW  = 20'd120000,
    parameter int unsigned REPEAT_FIRST = 4,
    parameter int unsigned REPEAT_EVERY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic       press,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_repeat,
    output logic       key_valid,
    output logic [2:0] fifo_level,
    output logic       overflow
);

`ifdef IR_AUTOREPEAT_EN
    localparam int unsigned EntryW = 9;
`else
    localparam int unsigned EntryW = 8;
`endif

    localparam logic StIdle = 1'b0;
    localparam logic StHeld = 1'b1;

    // ---------------------------------------------------------------- frame edge detect
    logic       press_d;
    logic       armed;     // press_d holds a real sample of press=0 taken after reset
    logic       fe;        // registered frame event, true the cycle after the press rise
    logic [7:0] code_cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            press_d  <= 1'b0;
            armed    <= 1'b0;
            fe       <= 1'b0;
            code_cap <= 8'h00;
        end else begin
            press_d <= press;
            fe      <= press & ~press_d & armed;
            if (!press) begin
                armed <= 1'b1;
            end
            if (press & ~press_d) begin
                code_cap <= code;
            end
        end
    end

    // ---------------------------------------------------------------- hold window
    logic [19:0] win;

    always_ff @(posedge clk) begin
        if (rst) begin
            win <= 20'd0;
        end else if (fe) begin
            win <= HOLD_WINDOW;
        end else if (win != 20'd0) begin
            win <= win - 20'd1;
        end
    end

    // ---------------------------------------------------------------- press / hold FSM
    logic       state;
    logic [7:0] last_code;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    logic       same_held;
    logic       rep_hit;
    int unsigned n_val;

    assign hold_nxt  = (hold_cnt == 8'hff) ? 8'hff : hold_cnt + 8'd1;
    assign same_held = (state == StHeld) && (code_cap == last_code) && (win != 20'd0);
    assign n_val     = 32'(hold_nxt);
    assign rep_hit   = (n_val >= REPEAT_FIRST) && (((n_val - REPEAT_FIRST) % REPEAT_EVERY) == 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            last_code <= 8'h00;
            hold_cnt  <= 8'h00;
        end else if (fe) begin
            if (same_held) begin
                hold_cnt <= hold_nxt;
            end else begin
                last_code <= code_cap;
                hold_cnt  <= 8'h00;
                state     <= StHeld;
            end
        end else if (state == StHeld && win == 20'd0) begin
            state <= StIdle;
        end
    end

    // ---------------------------------------------------------------- event generation
    logic              push;
    logic [EntryW-1:0] push_entry;

`ifdef IR_AUTOREPEAT_EN
    always_comb begin
        push       = 1'b0;
        push_entry = {1'b0, code_cap};
        if (fe) begin
            if (same_held) begin
                push       = rep_hit;
                push_entry = {1'b1, last_code};
            end else begin
                push = 1'b1;
            end
        end
    end
`else
    logic unused_rep_hit;
    assign unused_rep_hit = rep_hit;

    always_comb begin
        push       = fe & ~same_held;
        push_entry = code_cap;
    end
`endif

    // ---------------------------------------------------------------- event FIFO
    logic [EntryW-1:0] mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic [EntryW-1:0] head;

    assign full    = (count == 3'd4);
    assign pop     = key_valid & key_ready;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign key_valid  = (count != 3'd0);
    assign fifo_level = count;
    // Gate the head so stale RAM contents never show while empty.
    assign key_code   = key_valid ? head[7:0] : 8'h00;
`ifdef IR_AUTOREPEAT_EN
    assign key_repeat = key_valid & head[8];
`else
    assign key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_ir_key_scheduler.sv
// tb_ir_key_scheduler
//
// Directed bench for ir_key_scheduler. The hold window is scaled down to 120 cycles, so a
// frame spacing of 108 cycles models 108 ms and 200 cycles models 200 ms. Works for both
// builds (IR_AUTOREPEAT_EN defined or not).

module tb_ir_key_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] code;
    logic       press;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_repeat;
    logic       key_valid;
    logic [2:0] fifo_level;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ev_code [$];
    logic       ev_rep  [$];

    ir_key_scheduler #(
        .HOLD_WINDOW (20'd120),
        .REPEAT_FIRST(4),
        .REPEAT_EVERY(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .code      (code),
        .press     (press),
        .key_ready (key_ready),
        .key_code  (key_code),
        .key_repeat(key_repeat),
        .key_valid (key_valid),
        .fifo_level(fifo_level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change only just after posedge, so the values seen at negedge are those the
    // next posedge acts on.
    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            ev_code.push_back(key_code);
            ev_rep.push_back(key_repeat);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        press     = 1'b0;
        key_ready = 1'b0;
        code      = 8'h00;
        tick(2);
        rst = 1'b0;
        tick(1);
        ev_code.delete();
        ev_rep.delete();
    endtask

    // One frame: press high for 3 cycles, then low until the period is used up.
    task automatic frame(input logic [7:0] c, input int period);
        code  = c;
        press = 1'b1;
        tick(3);
        press = 1'b0;
        tick(period - 3);
    endtask

    function automatic logic [31:0] ev_code_at(input int i);
        return (i < ev_code.size()) ? 32'(ev_code[i]) : 32'hffff_ffff;
    endfunction

    function automatic logic [31:0] ev_rep_at(input int i);
        return (i < ev_rep.size()) ? 32'(ev_rep[i]) : 32'hffff_ffff;
    endfunction

    initial begin
        logic [7:0] fill_codes [4];
        logic [7:0] drain_codes [4];
        int         n_hold;
        logic       hold_rep [5];

`ifdef IR_AUTOREPEAT_EN
        n_hold   = 4;
        hold_rep = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        n_hold   = 1;
        hold_rep = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        // Reset values
        rst = 1'b1; press = 1'b0; key_ready = 1'b0; code = 8'h00;
        tick(2);
        check_eq("rst_valid", 32'(key_valid), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_code", 32'(key_code), 32'd0);
        check_eq("rst_rep", 32'(key_repeat), 32'd0);

        // Single press, 2-edge latency, then pop
        do_reset();
        code  = 8'h45;
        press = 1'b1;
        tick(1);
        check_eq("single_lat1_valid", 32'(key_valid), 32'd0);
        tick(1);
        check_eq("single_valid", 32'(key_valid), 32'd1);
        check_eq("single_code", 32'(key_code), 32'h45);
        check_eq("single_rep", 32'(key_repeat), 32'd0);
        check_eq("single_level", 32'(fifo_level), 32'd1);
        press     = 1'b0;
        key_ready = 1'b1;
        tick(1);
        check_eq("single_pop_level", 32'(fifo_level), 32'd0);
        check_eq("single_pop_valid", 32'(key_valid), 32'd0);
        key_ready = 1'b0;

        // Held key: 9 frames at 108, then a 10th after a 200 gap
        do_reset();
        key_ready = 1'b1;
        for (int i = 0; i < 9; i++) frame(8'h18, 108);
        check_eq("hold_count", 32'(ev_code.size()), 32'(n_hold));
        for (int i = 0; i < n_hold; i++) begin
            check_eq($sformatf("hold_code%0d", i), ev_code_at(i), 32'h18);
            check_eq($sformatf("hold_rep%0d", i), ev_rep_at(i), 32'(hold_rep[i]));
        end
        tick(92);
        frame(8'h18, 20);
        check_eq("hold_late_count", 32'(ev_code.size()), 32'(n_hold + 1));
        check_eq("hold_late_code", ev_code_at(n_hold), 32'h18);
        check_eq("hold_late_rep", ev_rep_at(n_hold), 32'd0);

        // Code change inside the window
        do_reset();
        key_ready = 1'b1;
        frame(8'h45, 108);
        frame(8'h46, 108);
        check_eq("chg_count", 32'(ev_code.size()), 32'd2);
        check_eq("chg_code0", ev_code_at(0), 32'h45);
        check_eq("chg_rep0", ev_rep_at(0), 32'd0);
        check_eq("chg_code1", ev_code_at(1), 32'h46);
        check_eq("chg_rep1", ev_rep_at(1), 32'd0);

        // Overflow, then simultaneous push/pop while full
        do_reset();
        for (int i = 0; i < 5; i++) frame(8'h11 + 8'(i), 6);
        check_eq("ovf_level", 32'(fifo_level), 32'd4);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_head", 32'(key_code), 32'h11);
        code  = 8'h16;
        press = 1'b1;
        tick(1);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        press     = 1'b0;
        check_eq("pp_level", 32'(fifo_level), 32'd4);
        check_eq("pp_ovf_sticky", 32'(overflow), 32'd1);
        drain_codes = '{8'h12, 8'h13, 8'h14, 8'h16};
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("pp_head%0d", i), 32'(key_code), 32'(drain_codes[i]));
            key_ready = 1'b1;
            tick(1);
            key_ready = 1'b0;
        end
        check_eq("pp_empty_valid", 32'(key_valid), 32'd0);
        check_eq("pp_empty_level", 32'(fifo_level), 32'd0);

        // Reset mid-operation with press held high
        do_reset();
        fill_codes = '{8'h31, 8'h32, 8'h33, 8'h00};
        frame(fill_codes[0], 6);
        frame(fill_codes[1], 6);
        code  = fill_codes[2];
        press = 1'b1;
        tick(3);
        check_eq("mid_level", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        tick(1);
        check_eq("mid_rst_valid", 32'(key_valid), 32'd0);
        check_eq("mid_rst_level", 32'(fifo_level), 32'd0);
        check_eq("mid_rst_code", 32'(key_code), 32'd0);
        check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick(10);
        check_eq("mid_held_valid", 32'(key_valid), 32'd0);
        check_eq("mid_held_level", 32'(fifo_level), 32'd0);
        press = 1'b0;
        tick(2);
        code  = 8'h27;
        press = 1'b1;
        tick(2);
        check_eq("mid_new_valid", 32'(key_valid), 32'd1);
        check_eq("mid_new_code", 32'(key_code), 32'h27);
        check_eq("mid_new_level", 32'(fifo_level), 32'd1);
        press = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
